tetris_grid_buffer: RTL
=======================

# tetris_grid_buffer

Parametrised, double-buffered bit grid for the Tetris playfield. Game logic writes individual cells into a back buffer. The VGA renderer reads cells from a front buffer. A requested swap copies the back buffer into the front buffer only at end of frame, so the renderer never sees a half-updated grid. Per-row "full" flags are also computed from the back buffer for line-clear logic.

## Interface
- GRID_W, 8, cells per row (x range 0..GRID_W-1)
- GRID_H, 18, rows (y range 0..GRID_H-1)
- COORD_W, 8, width of all x/y coordinate ports

- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- rd_x  in  COORD_W  renderer read column
- rd_y  in  COORD_W  renderer read row
- rd_value  out  1  front-buffer cell at (rd_x, rd_y), registered
- wr_en  in  1  write one back-buffer cell this cycle
- wr_x  in  COORD_W  write column
- wr_y  in  COORD_W  write row
- wr_data  in  1  cell value to write
- clr_back  in  1  clear entire back buffer this cycle
- swap_req  in  1  pulse: request back→front copy at next frame end
- frame_end  in  1  pulse from renderer: frame draw finished
- swap_pending  out  1  a request is waiting for frame_end
- swap_done  out  1  one-cycle pulse, the cycle after a copy
- row_full  out  GRID_H  bit y = 1 when every cell of back row y is 1, registered

## Operation
- Storage: front and back, GRID_W*GRID_H bits each. Cell (x,y) maps to index x + GRID_W*y; row 0 is the top row.
- Range check: a coordinate is valid iff x < GRID_W and y < GRID_H, compared at full COORD_W width. There is no truncation or wrap.
- Read: rd_value <= front[idx(rd_x, rd_y)] if valid, else 0. Reads run every cycle, including frame_end cycles.
- Write: if wr_en and valid, back[idx] <= wr_data. Invalid writes are dropped silently.
- clr_back: all back bits <= 0. If wr_en is asserted the same cycle, clr_back wins and the write is dropped.
- Swap controller, states IDLE / PENDING:
  - IDLE: swap_req with no frame_end → PENDING.
  - IDLE: swap_req with frame_end in the same cycle → copy immediately, stay IDLE.
  - PENDING: frame_end → copy, → IDLE.
  - PENDING: further swap_req pulses are absorbed, with no queueing.
- swap_pending = 1 exactly in PENDING.
- Copy: front <= back, using back's pre-edge value. Back is unchanged by a copy, so game state persists.
- row_full[y] <= AND of back row y, evaluated on post-edge back contents. It lags back-buffer changes by one cycle.

## Timing
- Reset values: front = 0, back = 0, state IDLE, rd_value 0, swap_pending 0, swap_done 0, row_full 0.
- rst overrides all other inputs that cycle and aborts a pending swap.
- Read latency is 1 cycle: address at edge N, data valid after edge N.
- The read issued on the copy edge returns the old front value. The new front is visible from the next read.
- A write and a copy on the same edge: the copy takes the old back value; the write lands in back only. It reaches front on the next swap.
- clr_back and a copy on the same edge: front gets the old back value, then back is cleared.
- swap_done is high for exactly the one cycle after the copy edge.
- row_full reflects a write one cycle after the write edge (2 edges after wr_en is sampled).
- Throughput: one read and one write per cycle, with no stalls.

## Test plan
- Reset and range check: assert rst 1 cycle. Read (0,0), (7,17), (8,0), (0,18), (255,255) → rd_value 0 every cycle; swap_pending=0, row_full=0.
- Deferred swap: write (3,5)=1 and (7,17)=1; pulse swap_req → swap_pending=1, reads of (3,5) still return 0. Pulse frame_end → swap_done=1 next cycle, swap_pending=0, (3,5) and (7,17) read 1, (4,5) reads 0.
- Same-edge swap: swap_req with frame_end in the same cycle from IDLE → copy on that edge, swap_pending never 1. Then write (2,2)=1 on the same edge as a copy → front (2,2)=0 and back keeps 1; the next swap makes front (2,2)=1.
- Row full: write x=0..7 of row 17 to 1 → row_full = 18'h20000 one cycle after the last write. Write (0,17)=0 → row_full = 0. Issue clr_back together with wr_en (1,1)=1 → back all 0.
- Invalid write: wr_en at (8,3) and (0,18) with data 1, then swap → all front cells read 0 and row_full is unchanged.
- Reset mid-pending: swap_req, then rst before frame_end → swap_pending=0. A later frame_end performs no copy, and the front stays 0.

Source files
------------

// File: rtl/tetris_grid_buffer.sv
// rtl/tetris_grid_buffer.sv - double-buffered Tetris playfield bit grid
// Game logic writes the back grid; the renderer reads the front grid, refreshed only at frame end.
module tetris_grid_buffer #(
  parameter int GRID_W  = 8,
  parameter int GRID_H  = 18,
  parameter int COORD_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COORD_W-1:0] rd_x,
  input  logic [COORD_W-1:0] rd_y,
  output logic               rd_value,
  input  logic               wr_en,
  input  logic [COORD_W-1:0] wr_x,
  input  logic [COORD_W-1:0] wr_y,
  input  logic               wr_data,
  input  logic               clr_back,
  input  logic               swap_req,
  input  logic               frame_end,
  output logic               swap_pending,
  output logic               swap_done,
  output logic [GRID_H-1:0]  row_full
);

  localparam int CELLS = GRID_W * GRID_H;
  localparam int IDX_W = $clog2(CELLS);

  typedef enum logic {IDLE, PENDING} state_t;

  state_t state, state_next;
  logic   do_copy;

  logic [CELLS-1:0]  front;
  logic [CELLS-1:0]  back;
  logic [GRID_H-1:0] row_and;

  logic             rd_valid, wr_valid;
  logic [IDX_W-1:0] rd_idx, wr_idx;

  // Bounds are checked at full coordinate width so out-of-range cells never alias real ones.
  always_comb begin
    rd_valid = (32'(rd_x) < 32'(GRID_W)) && (32'(rd_y) < 32'(GRID_H));
    wr_valid = (32'(wr_x) < 32'(GRID_W)) && (32'(wr_y) < 32'(GRID_H));
    rd_idx   = IDX_W'(32'(rd_x) + 32'(GRID_W) * 32'(rd_y));
    wr_idx   = IDX_W'(32'(wr_x) + 32'(GRID_W) * 32'(wr_y));
  end

  always_comb begin
    state_next = state;
    do_copy    = 1'b0;
    case (state)
      IDLE: begin
        if (swap_req) begin
          if (frame_end) do_copy = 1'b1;
          else           state_next = PENDING;
        end
      end
      PENDING: begin
        if (frame_end) begin
          do_copy    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  assign swap_pending = (state == PENDING);

  // Copy samples back's pre-edge value, so same-edge writes or clears land in back only.
  always_ff @(posedge clk) begin
    if (rst) begin
      front     <= '0;
      back      <= '0;
      swap_done <= 1'b0;
    end else begin
      if (do_copy) front <= back;
      swap_done <= do_copy;
      if (clr_back)
        back <= '0;
      else if (wr_en && wr_valid)
        back[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)           rd_value <= 1'b0;
    else if (rd_valid) rd_value <= front[rd_idx];
    else               rd_value <= 1'b0;
  end

  always_comb begin
    row_and = '0;
    for (int y = 0; y < GRID_H; y++)
      row_and[y] = &back[y*GRID_W +: GRID_W];
  end

  // Registered from the back register, so flags trail cell updates by one cycle.
  always_ff @(posedge clk) begin
    if (rst) row_full <= '0;
    else     row_full <= row_and;
  end

endmodule
